// File: rtl/ctrl_pipe_if.sv
// Control-pipe bundle: ID-stage instruction fields in, staged EX/M/WB control out.
// Latency: none, wiring only.
// Backpressure: stall is the only upstream hold; there is no ready signal.
interface ctrl_pipe_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [5:0]       opcode;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             branch_taken;
  logic [3:0]       idex_ex;
  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [2:0]       exmem_m;
  logic [1:0]       exmem_wb;
  logic [1:0]       memwb_wb;
  logic             stall;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  // Pipeline-front side: supplies instructions and the flush request.
  modport master (
    output id_valid, opcode, id_rs, id_rt, branch_taken,
    input  idex_ex, idex_m, idex_wb, exmem_m, exmem_wb, memwb_wb,
    input  stall, illegal, illegal_cnt
  );

  // Control-pipe side.
  modport slave (
    input  id_valid, opcode, id_rs, id_rt, branch_taken,
    output idex_ex, idex_m, idex_wb, exmem_m, exmem_wb, memwb_wb,
    output stall, illegal, illegal_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Decodes the ID opcode and carries EX/M/WB control through ID/EX, EX/MEM and MEM/WB.
// Latency: idex_* 1 edge, exmem_* 2 edges, memwb_wb 3 edges after ID.
// Backpressure: combinational stall on load-use inserts a bubble; a taken branch flushes ID/EX and EX/MEM.
module ctrl_pipe #(
  parameter int RA_W      = 5,
  parameter int CNT_W     = 8,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  ctrl_pipe_if.slave    bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  logic [3:0]      dec_ex;
  logic [2:0]      dec_m;
  logic [1:0]      dec_wb;
  logic            dec_ill;
  logic            rt_hit;
  logic            stall_w;
  logic            adv_ill;

  logic [3:0]      idex_ex_q,  idex_ex_d;
  logic [2:0]      idex_m_q,   idex_m_d;
  logic [1:0]      idex_wb_q,  idex_wb_d;
  logic [RA_W-1:0] idex_rt_q,  idex_rt_d;
  logic [2:0]      exmem_m_q,  exmem_m_d;
  logic [1:0]      exmem_wb_q, exmem_wb_d;
  logic [1:0]      memwb_wb_q, memwb_wb_d;
  logic            illegal_q,  illegal_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Main decoder; a bubble (id_valid=0) and an illegal opcode both yield all-zero control.
  always_comb begin
    dec_ex  = 4'b0000;
    dec_m   = 3'b000;
    dec_wb  = 2'b00;
    dec_ill = 1'b0;
    if (bus.id_valid) begin
      case (bus.opcode)
        OP_RTYPE: begin dec_ex = 4'b1100; dec_wb = 2'b10; end
        OP_LW:    begin dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b11; end
        OP_SW:    begin dec_ex = 4'b0001; dec_m = 3'b001; end
        OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 3'b100; end
        OP_NOP:   ;
        default:  dec_ill = 1'b1;
      endcase
    end
  end

  // A load in EX whose destination feeds the ID instruction must hold ID one cycle; a flush overrides it.
  assign rt_hit  = (idex_rt_q == bus.id_rs) | (idex_rt_q == bus.id_rt);
  assign stall_w = HAZARD_EN & bus.id_valid & idex_m_q[1] & rt_hit & ~bus.branch_taken;
  assign adv_ill = dec_ill & ~stall_w & ~bus.branch_taken;

  // Next-state for all pipeline control registers and the illegal-opcode tracker.
  always_comb begin
    idex_ex_d  = dec_ex;
    idex_m_d   = dec_m;
    idex_wb_d  = dec_wb;
    idex_rt_d  = idex_rt_q;
    if (bus.id_valid && !dec_ill) begin
      idex_rt_d = bus.id_rt;
    end
    if (stall_w || bus.branch_taken) begin
      idex_ex_d = 4'b0000;
      idex_m_d  = 3'b000;
      idex_wb_d = 2'b00;
      idex_rt_d = idex_rt_q;
    end
    exmem_m_d  = bus.branch_taken ? 3'b000 : idex_m_q;
    exmem_wb_d = bus.branch_taken ? 2'b00  : idex_wb_q;
    // MEM/WB always advances: on a flush it receives the resolving branch, whose WB is 00.
    memwb_wb_d = exmem_wb_q;
    illegal_d  = illegal_q | adv_ill;
    cnt_d      = cnt_q;
    if (adv_ill && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards all in-flight control at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ex_q  <= '0;
      idex_m_q   <= '0;
      idex_wb_q  <= '0;
      idex_rt_q  <= '0;
      exmem_m_q  <= '0;
      exmem_wb_q <= '0;
      memwb_wb_q <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      idex_ex_q  <= idex_ex_d;
      idex_m_q   <= idex_m_d;
      idex_wb_q  <= idex_wb_d;
      idex_rt_q  <= idex_rt_d;
      exmem_m_q  <= exmem_m_d;
      exmem_wb_q <= exmem_wb_d;
      memwb_wb_q <= memwb_wb_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.idex_ex     = idex_ex_q;
  assign bus.idex_m      = idex_m_q;
  assign bus.idex_wb     = idex_wb_q;
  assign bus.exmem_m     = exmem_m_q;
  assign bus.exmem_wb    = exmem_wb_q;
  assign bus.memwb_wb    = memwb_wb_q;
  assign bus.stall       = stall_w;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench: two control pipes (hazard on / CNT_W=8, hazard off / CNT_W=2) share one stimulus stream.
// Expected outputs come from an instruction-level pipeline model and are queued per cycle.
// A negedge monitor pops and compares every output of both instances.
module tb_ctrl_pipe;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;
  localparam logic [5:0] OP_ILL   = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.RA_W(5), .CNT_W(8)) bus_a ();
  ctrl_pipe_if #(.RA_W(5), .CNT_W(2)) bus_b ();

  ctrl_pipe #(.RA_W(5), .CNT_W(8), .HAZARD_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  ctrl_pipe #(.RA_W(5), .CNT_W(2), .HAZARD_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Instruction occupying a pipeline stage (v=0 is a bubble).
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rt;
  } rec_t;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [2:0] xm;
    logic [1:0] xwb;
    logic [1:0] mwb;
    logic       st;
    logic       il;
    logic [7:0] cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model state per configuration: index 0 = dut_a, 1 = dut_b.
  rec_t pipe [2][3];
  int   cnt  [2];
  bit   ill  [2];
  int   cmax [2] = '{255, 3};
  bit   hen  [2] = '{1'b1, 1'b0};

  // Control table from the decoder truth table: {EX, M, WB}.
  function automatic logic [8:0] ctl(rec_t r);
    if (!r.v) return 9'd0;
    case (r.op)
      OP_RTYPE: return 9'b1100_000_10;
      OP_LW:    return 9'b0001_010_11;
      OP_SW:    return 9'b0001_001_00;
      OP_BEQ:   return 9'b0010_100_00;
      default:  return 9'd0;
    endcase
  endfunction

  function automatic bit legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_NOP);
  endfunction

  task automatic mreset(int c);
    for (int s = 0; s < 3; s++) pipe[c][s] = '0;
    cnt[c] = 0;
    ill[c] = 1'b0;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus. rmode: 0 keep reset level, 1 release reset, 2 assert reset mid-cycle.
  task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input bit bt, input int rmode, output bit st0);
    exp_t e;
    logic [8:0] d0, d1, d2;
    bit st;
    @(posedge clk);
    #1;
    if (rmode == 1) rst_n = 1'b1;
    bus_a.id_valid = v;  bus_a.opcode = op;  bus_a.id_rs = rs;  bus_a.id_rt = rt;  bus_a.branch_taken = bt;
    bus_b.id_valid = v;  bus_b.opcode = op;  bus_b.id_rs = rs;  bus_b.id_rt = rt;  bus_b.branch_taken = bt;
    if (rmode == 2) begin
      #2;
      rst_n = 1'b0;
    end
    st0 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) mreset(c);
      st = hen[c] && v && pipe[c][0].v && (pipe[c][0].op == OP_LW) &&
           ((pipe[c][0].rt == rs) || (pipe[c][0].rt == rt)) && !bt;
      d0 = ctl(pipe[c][0]);
      d1 = ctl(pipe[c][1]);
      d2 = ctl(pipe[c][2]);
      e.ex = d0[8:5];  e.m = d0[4:2];  e.wb = d0[1:0];
      e.xm = d1[4:2];  e.xwb = d1[1:0];  e.mwb = d2[1:0];
      e.st = st;  e.il = ill[c];  e.cnt = 8'(cnt[c]);
      if (c == 0) begin q_a.push_back(e); st0 = st; end
      else        q_b.push_back(e);
      if (rst_n) begin
        if (v && !st && !bt && !legal(op)) begin
          ill[c] = 1'b1;
          if (cnt[c] < cmax[c]) cnt[c]++;
        end
        pipe[c][2] = pipe[c][1];
        pipe[c][1] = bt ? rec_t'(0) : pipe[c][0];
        pipe[c][0] = (bt || st || !v) ? rec_t'(0) : rec_t'{1'b1, op, rt};
      end
    end
  endtask

  // Issue an instruction, reissuing it while dut_a reports a stall.
  task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input bit bt);
    bit s;
    int tries = 0;
    do begin
      drive(1'b1, op, rs, rt, bt, 0, s);
      tries++;
    end while (s && tries < 4);
    if (s) chk("stall_bound", 32'(s), 32'd0);
  endtask

  // Monitor: every negedge, compare both instances against the head of their queues.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("A.idex_ex",  32'(bus_a.idex_ex),     32'(e.ex));
      chk("A.idex_m",   32'(bus_a.idex_m),      32'(e.m));
      chk("A.idex_wb",  32'(bus_a.idex_wb),     32'(e.wb));
      chk("A.exmem_m",  32'(bus_a.exmem_m),     32'(e.xm));
      chk("A.exmem_wb", 32'(bus_a.exmem_wb),    32'(e.xwb));
      chk("A.memwb_wb", 32'(bus_a.memwb_wb),    32'(e.mwb));
      chk("A.stall",    32'(bus_a.stall),       32'(e.st));
      chk("A.illegal",  32'(bus_a.illegal),     32'(e.il));
      chk("A.cnt",      32'(bus_a.illegal_cnt), 32'(e.cnt));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("B.idex_ex",  32'(bus_b.idex_ex),     32'(e.ex));
      chk("B.idex_m",   32'(bus_b.idex_m),      32'(e.m));
      chk("B.idex_wb",  32'(bus_b.idex_wb),     32'(e.wb));
      chk("B.exmem_m",  32'(bus_b.exmem_m),     32'(e.xm));
      chk("B.exmem_wb", 32'(bus_b.exmem_wb),    32'(e.xwb));
      chk("B.memwb_wb", 32'(bus_b.memwb_wb),    32'(e.mwb));
      chk("B.stall",    32'(bus_b.stall),       32'(e.st));
      chk("B.illegal",  32'(bus_b.illegal),     32'(e.il));
      chk("B.cnt",      32'(bus_b.illegal_cnt), 32'(e.cnt));
    end
  end

  initial begin
    bit s;
    logic       v;
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit         bt;
    int         wait_cnt;
    logic [5:0] optab [7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_NOP, OP_ILL, 6'b010101};

    rst_n = 1'b0;
    bus_a.id_valid = 1'b0; bus_a.opcode = '0; bus_a.id_rs = '0; bus_a.id_rt = '0; bus_a.branch_taken = 1'b0;
    bus_b.id_valid = 1'b0; bus_b.opcode = '0; bus_b.id_rs = '0; bus_b.id_rt = '0; bus_b.branch_taken = 1'b0;
    mreset(0);
    mreset(1);

    // Reset state, then release.
    drive(1'b1, OP_LW, 5'd1, 5'd1, 1'b0, 0, s);
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 0, s);
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 1, s);

    // Every opcode back to back, then drain.
    issue(OP_RTYPE, 5'd1, 5'd2, 1'b0);
    issue(OP_LW,    5'd3, 5'd4, 1'b0);
    issue(OP_SW,    5'd8, 5'd9, 1'b0);
    issue(OP_BEQ,   5'd1, 5'd2, 1'b0);
    issue(OP_NOP,   5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) issue(OP_NOP, 5'd0, 5'd0, 1'b0);

    // Load-use: one bubble, then the RTYPE bundle.
    issue(OP_LW,    5'd0, 5'd5, 1'b0);
    issue(OP_RTYPE, 5'd5, 5'd6, 1'b0);
    issue(OP_NOP,   5'd0, 5'd0, 1'b0);
    issue(OP_NOP,   5'd0, 5'd0, 1'b0);

    // Taken branch pulsed while the BEQ sits in EX/MEM.
    issue(OP_BEQ,   5'd1, 5'd2, 1'b0);
    issue(OP_RTYPE, 5'd1, 5'd2, 1'b0);
    issue(OP_RTYPE, 5'd3, 5'd4, 1'b1);
    issue(OP_NOP,   5'd0, 5'd0, 1'b0);
    issue(OP_NOP,   5'd0, 5'd0, 1'b0);

    // Load-use coinciding with a flush, using an illegal opcode so the count must not move.
    issue(OP_LW, 5'd0, 5'd7, 1'b0);
    drive(1'b1, OP_ILL, 5'd7, 5'd0, 1'b1, 0, s);
    issue(OP_NOP, 5'd0, 5'd0, 1'b0);

    // Three illegal opcodes, the first one stalled once before it advances.
    issue(OP_LW,  5'd0, 5'd3, 1'b0);
    issue(OP_ILL, 5'd3, 5'd0, 1'b0);
    issue(OP_ILL, 5'd1, 5'd2, 1'b0);
    issue(OP_ILL, 5'd1, 5'd2, 1'b0);
    issue(OP_NOP, 5'd0, 5'd0, 1'b0);
    issue(OP_NOP, 5'd0, 5'd0, 1'b0);

    // Random traffic on a small register range so hazards are frequent; stalled instructions are held.
    s = 1'b0;
    v = 1'b0; op = OP_NOP; rs = '0; rt = '0;
    for (int i = 0; i < 400; i++) begin
      if (!s) begin
        v  = ($urandom_range(0, 7) != 0);
        op = optab[$urandom_range(0, 6)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
      end
      bt = ($urandom_range(0, 9) == 0);
      drive(v, op, rs, rt, bt, 0, s);
    end

    // Reset asserted between edges with a load in EX.
    issue(OP_LW, 5'd0, 5'd2, 1'b0);
    drive(1'b1, OP_RTYPE, 5'd3, 5'd1, 1'b0, 2, s);
    drive(1'b1, OP_LW, 5'd0, 5'd0, 1'b0, 0, s);
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 1, s);
    issue(OP_RTYPE, 5'd1, 5'd2, 1'b0);
    issue(OP_NOP,   5'd0, 5'd0, 1'b0);

    wait_cnt = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q_a.size() > 0 || q_b.size() > 0) chk("drain", 32'(q_a.size() + q_b.size()), 32'd0);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
